seg_mux_display: RTL

- Time-multiplexed N-digit seven-segment driver; successor to the single-digit hex decoder.
- Scans NUM_DIGITS common-anode digits from one shared segment bus.
- Adds:
  - per-digit enable
  - decimal points
  - leading-zero suppression
  - anti-ghosting blank time between digits
  - frame-synchronous atomic update of the displayed value
- Sits between the note/frequency result logic and the board's LED/anode pins.

---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_display.sv | 32 +++
 rtl/seg_mux_display.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment types and constants for the display drivers.
// Segment vectors are active-low, with bit 6 = a down to bit 0 = g.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

endpackage

// File: rtl/seg_display.sv
// Combinational hex-to-seven-segment decoder (active-low segments, a..g = bit6..bit0).
module seg_display
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (hex)
            4'h0: segments = 7'b0000001;
            4'h1: segments = 7'b1001111;
            4'h2: segments = 7'b0010010;
            4'h3: segments = 7'b0000110;
            4'h4: segments = 7'b1001100;
            4'h5: segments = 7'b0100100;
            4'h6: segments = 7'b0100000;
            4'h7: segments = 7'b0001111;
            4'h8: segments = 7'b0000000;
            4'h9: segments = 7'b0000100;
            4'hA: segments = 7'b0001000;
            4'hB: segments = 7'b1100000;
            4'hC: segments = 7'b0110001;
            4'hD: segments = 7'b1000010;
            4'hE: segments = 7'b0110000;
            4'hF: segments = 7'b0111000;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_mux_display.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS digits on a shared segment bus,
// with per-digit enable, decimal points, leading-zero suppression and frame-atomic updates.
module seg_mux_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int DIGIT_CYCLES     = 20000,
    parameter int BLANK_CYCLES     = 256,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic                    lz_en_i,
    input  logic                    load_i,
    output seg_t                    segments,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done
);

    localparam int SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

    logic [SLOT_W-1:0] slot_cnt_reg;
    logic [IDX_W-1:0]  dig_idx_reg;

    logic [NUM_DIGITS-1:0][3:0] pend_value_reg, disp_value_reg;
    logic [NUM_DIGITS-1:0]      pend_dp_reg, disp_dp_reg;
    logic [NUM_DIGITS-1:0]      pend_en_reg, disp_en_reg;
    logic                       pend_valid_reg;

    seg_t                  segments_reg;
    logic                  dp_reg;
    logic [NUM_DIGITS-1:0] anodes_reg;
    logic                  frame_done_reg;

    logic frame_boundary;
    assign frame_boundary = (slot_cnt_reg == SLOT_LAST) && (dig_idx_reg == IDX_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt_reg <= '0;
            dig_idx_reg  <= '0;
        end else if (slot_cnt_reg == SLOT_LAST) begin
            slot_cnt_reg <= '0;
            dig_idx_reg  <= (dig_idx_reg == IDX_LAST) ? '0 : dig_idx_reg + IDX_W'(1);
        end else begin
            slot_cnt_reg <= slot_cnt_reg + SLOT_W'(1);
        end
    end

    // A load landing on the boundary bypasses pending so it is shown in the very next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_value_reg <= '0;
            pend_dp_reg    <= '0;
            pend_en_reg    <= '0;
            pend_valid_reg <= 1'b0;
            disp_value_reg <= '0;
            disp_dp_reg    <= '0;
            disp_en_reg    <= '0;
        end else if (load_i && frame_boundary) begin
            disp_value_reg <= value_i;
            disp_dp_reg    <= dp_i;
            disp_en_reg    <= digit_en_i;
            pend_valid_reg <= 1'b0;
        end else if (load_i) begin
            pend_value_reg <= value_i;
            pend_dp_reg    <= dp_i;
            pend_en_reg    <= digit_en_i;
            pend_valid_reg <= 1'b1;
        end else if (frame_boundary && pend_valid_reg) begin
            disp_value_reg <= pend_value_reg;
            disp_dp_reg    <= pend_dp_reg;
            disp_en_reg    <= pend_en_reg;
            pend_valid_reg <= 1'b0;
        end
    end

    // Walk down from the most significant digit while nibbles stay zero; digit 0 is never reached.
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  lz_run;
    always_comb begin
        lz_blank = '0;
        lz_run   = lz_en_i;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run      = lz_run && (disp_value_reg[i] == 4'd0);
            lz_blank[i] = lz_run;
        end
    end

    logic [NUM_DIGITS-1:0] digit_blank;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
        assign digit_blank[gi] = !disp_en_reg[gi] || lz_blank[gi];
    end

    logic in_blank_time;
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign in_blank_time = 1'b0;
    end else begin : g_blank_time
        assign in_blank_time = slot_cnt_reg < SLOT_W'(BLANK_CYCLES);
    end

    seg_t                  glyph;
    logic                  show_digit;
    logic [NUM_DIGITS-1:0] anode_on;

    seg_display u_decoder (
        .hex      (disp_value_reg[dig_idx_reg]),
        .segments (glyph)
    );

    assign show_digit = !in_blank_time && !digit_blank[dig_idx_reg];
    assign anode_on   = NUM_DIGITS'(1) << dig_idx_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            segments_reg   <= SEG_BLANK;
            dp_reg         <= 1'b1;
            anodes_reg     <= ANODE_OFF;
            frame_done_reg <= 1'b0;
        end else begin
            segments_reg   <= show_digit ? glyph : SEG_BLANK;
            dp_reg         <= show_digit ? !disp_dp_reg[dig_idx_reg] : 1'b1;
            anodes_reg     <= show_digit ? (anode_on ^ ANODE_OFF) : ANODE_OFF;
            frame_done_reg <= frame_boundary;
        end
    end

    assign segments   = segments_reg;
    assign dp_o       = dp_reg;
    assign anodes     = anodes_reg;
    assign frame_done = frame_done_reg;

endmodule
